// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB slave with byte-strobed word storage and zero wait states
module apb_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic                    PCLK,
    input  logic                    reset,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic [ADDR_WIDTH-3:0] word_addr;
    logic [IDX_W-1:0]      word_idx;
    logic                  addr_valid;
    logic                  setup_cyc;
    logic                  access_cyc;
    logic                  access_err;
    logic                  wr_en;
    logic                  rd_capture;

    // Address decode: word-aligned and inside the storage array
    always_comb begin
        word_addr  = PADDR[ADDR_WIDTH-1:2];
        word_idx   = word_addr[IDX_W-1:0];
        addr_valid = (PADDR[1:0] == 2'b00) && (word_addr < (ADDR_WIDTH-2)'(DEPTH));
    end

    // Phase qualifiers and the zero-wait handshake; errors are masked while reset is held
    always_comb begin
        setup_cyc  = PSEL & ~PENABLE;
        access_cyc = PSEL & PENABLE;
        access_err = access_cyc & ~reset & (~addr_valid | (state_q == ST_IDLE));
        wr_en      = access_cyc & PWRITE & ~access_err;
        rd_capture = setup_cyc & ~PWRITE;
        PREADY     = access_cyc;
        PSLVERR    = access_err;
        // An ACCESS read that never had a SETUP never captured data, so it reads as zero
        PRDATA     = (access_cyc & ~PWRITE & (state_q == ST_IDLE)) ? '0 : prdata_q;
    end

    // Protocol tracker next state; an ACCESS seen straight from IDLE stays in IDLE (error)
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (setup_cyc) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (access_cyc)  state_d = ST_ACCESS;
                else if (!PSEL)  state_d = ST_IDLE;
            end
            ST_ACCESS: begin
                if (setup_cyc)   state_d = ST_SETUP;
                else if (!PSEL)  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data is captured during the read SETUP so it is stable across ACCESS
    always_comb begin
        prdata_d = prdata_q;
        if (rd_capture) begin
            prdata_d = addr_valid ? mem_q[word_idx] : '0;
        end
    end

    // Byte-lane write merge into the addressed word
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (PSTRB[l]) begin
                    mem_d[word_idx][8*l +: 8] = PWDATA[8*l +: 8];
                end
            end
        end
    end

    // State, read register and storage; reset clears everything immediately
    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            prdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            prdata_q <= prdata_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - directed bench for apb_slave_mem with a behavioural storage model
module tb_apb_slave_mem;

    logic        PCLK = 1'b0;
    logic        reset;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int errors = 0;
    int checks = 0;

    apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64)) dut (
        .PCLK   (PCLK),
        .reset  (reset),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PSTRB  (PSTRB),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Behavioural model: word array, last captured read value, and whether the previous cycle was a SETUP
    logic [31:0] m_mem [64];
    logic [31:0] m_rdata;
    logic        m_prev_setup;

    function automatic bit addr_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < 64);
    endfunction

    always @(posedge PCLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) m_mem[i] <= 32'h0;
            m_rdata      <= 32'h0;
            m_prev_setup <= 1'b0;
        end else begin
            if (PSEL && PENABLE && PWRITE && m_prev_setup && addr_ok(PADDR)) begin
                for (int b = 0; b < 4; b++)
                    if (PSTRB[b]) m_mem[PADDR/4][8*b +: 8] <= PWDATA[8*b +: 8];
            end
            if (PSEL && !PENABLE && !PWRITE)
                m_rdata <= addr_ok(PADDR) ? m_mem[PADDR/4] : 32'h0;
            m_prev_setup <= PSEL && !PENABLE;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of DUT outputs against the model, away from the active edge
    always @(negedge PCLK) begin
        logic        exp_ready;
        logic        exp_err;
        logic [31:0] exp_rd;
        exp_ready = PSEL && PENABLE;
        exp_err   = !reset && PSEL && PENABLE && (!addr_ok(PADDR) || !m_prev_setup);
        exp_rd    = (PSEL && PENABLE && !PWRITE && !m_prev_setup) ? 32'h0 : m_rdata;
        check("mon_pready", {31'h0, PREADY}, {31'h0, exp_ready});
        check("mon_pslverr", {31'h0, PSLVERR}, {31'h0, exp_err});
        check("mon_prdata", PRDATA, exp_rd);
    end

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d; PSTRB = s;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        err = PSLVERR;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] rd, output logic err,
                            output logic rdy);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        rd  = PRDATA;
        err = PSLVERR;
        rdy = PREADY;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK); #1;
            PSEL = 1'b0; PENABLE = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        reset = 1'b1;
        @(posedge PCLK); #1;
        reset = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    logic        rdy;

    initial begin
        reset = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        @(negedge PCLK);
        check("reset_prdata", PRDATA, 32'h0);
        check("reset_pready", {31'h0, PREADY}, 32'h0);
        @(posedge PCLK); #1;
        reset = 1'b0;

        // Basic write/read of decimal 17
        apb_write(32'h0, 32'd17, 4'hF, err);
        check("wr0_pslverr", {31'h0, err}, 32'h0);
        idle(1);
        apb_read(32'h0, rd, err, rdy);
        check("rd0_data", rd, 32'h0000_0011);
        check("rd0_pslverr", {31'h0, err}, 32'h0);
        check("rd0_pready", {31'h0, rdy}, 32'h1);
        idle(1);

        // Second word leaves the first intact
        apb_write(32'h8, 32'h0041_5042, 4'hF, err);
        idle(1);
        apb_read(32'h8, rd, err, rdy);
        check("rd8_apb", rd, 32'h0041_5042);
        idle(1);
        apb_read(32'h0, rd, err, rdy);
        check("rd0_still", rd, 32'h0000_0011);
        idle(1);

        // After reset storage is clear; single-lane strobe merge
        do_reset();
        apb_read(32'h4, rd, err, rdy);
        check("rd4_after_reset", rd, 32'h0);
        idle(1);
        apb_write(32'h0, 32'h0000_0011, 4'hF, err);
        idle(1);
        apb_write(32'h0, 32'hFFFF_FFFF, 4'b0001, err);
        idle(1);
        apb_read(32'h0, rd, err, rdy);
        check("rd0_strobe", rd, 32'h0000_00FF);
        idle(1);

        // Misaligned and out-of-range accesses
        apb_write(32'h2, 32'hA5A5_A5A5, 4'hF, err);
        check("wr_misalign_err", {31'h0, err}, 32'h1);
        idle(1);
        apb_write(32'h100, 32'h5A5A_5A5A, 4'hF, err);
        check("wr_range_err", {31'h0, err}, 32'h1);
        idle(1);
        apb_read(32'h2, rd, err, rdy);
        check("rd_misalign_data", rd, 32'h0);
        check("rd_misalign_err", {31'h0, err}, 32'h1);
        idle(1);
        apb_read(32'h100, rd, err, rdy);
        check("rd_range_data", rd, 32'h0);
        idle(1);
        apb_read(32'h0, rd, err, rdy);
        check("rd0_unchanged", rd, 32'h0000_00FF);
        idle(1);

        // ACCESS with no SETUP: write is dropped, read returns zero
        apb_write(32'h8, 32'h1234_5678, 4'hF, err);
        idle(1);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h8; PWDATA = 32'hDEAD_BEEF; PSTRB = 4'hF;
        @(negedge PCLK);
        check("nosetup_wr_err", {31'h0, PSLVERR}, 32'h1);
        idle(1);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h8;
        @(negedge PCLK);
        check("nosetup_rd_err", {31'h0, PSLVERR}, 32'h1);
        check("nosetup_rd_data", PRDATA, 32'h0);
        idle(1);
        apb_read(32'h8, rd, err, rdy);
        check("rd8_not_written", rd, 32'h1234_5678);

        // Back-to-back write then read with no idle cycle
        apb_write(32'h8, 32'hCAFE_F00D, 4'hF, err);
        apb_read(32'h8, rd, err, rdy);
        check("b2b_rd8", rd, 32'hCAFE_F00D);
        check("b2b_err", {31'h0, err}, 32'h0);
        idle(1);

        // Reset asserted in the middle of a write ACCESS
        apb_write(32'h0, 32'h5555_5555, 4'hF, err);
        idle(1);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'h7777_7777; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("midreset_pslverr", {31'h0, PSLVERR}, 32'h0);
        check("midreset_pready", {31'h0, PREADY}, 32'h1);
        check("midreset_prdata", PRDATA, 32'h0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        reset = 1'b0;
        apb_read(32'h0, rd, err, rdy);
        check("rd0_after_midreset", rd, 32'h0);
        check("rd0_after_midreset_err", {31'h0, err}, 32'h0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: simulation did not complete, required completion before 50000");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
